// File: rtl/result_drain_pkg.sv
// Shared constants and FSM state type for the result-SRAM drain path.
// ROW_BW is also the result SRAM word width and the vector multiplier write width.
package result_drain_pkg;
    localparam int ADDRESSSIZE    = 10;
    localparam int PARTIAL_SUM_BW = 24;
    localparam int MATRIX_SIZE    = 32;
    localparam int ROW_BW         = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int IDX_W          = $clog2(MATRIX_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        SEND,
        FIN
    } drain_state_t;
endpackage

// File: rtl/result_drain_row_serializer.sv
// Row register that presents one element per advance, lowest element first,
// with an element index and a flag for the last element of the row.
module row_serializer
    import result_drain_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clear,
    input  logic                             i_load,
    input  logic [ROW_BW-1:0]                i_row,
    input  logic                             i_advance,
    output logic signed [PARTIAL_SUM_BW-1:0] o_elem,
    output logic                             o_row_last
);
    logic [ROW_BW-1:0] r_row_p0;
    logic [IDX_W-1:0]  r_idx;

    // Row data: shift right one element per accepted beat
    always_ff @(posedge clk) begin
        if (i_load)
            r_row_p0 <= i_row;
        else if (i_advance)
            r_row_p0 <= {{PARTIAL_SUM_BW{1'b0}}, r_row_p0[ROW_BW-1:PARTIAL_SUM_BW]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_idx <= '0;
        else if (i_clear || i_load)
            r_idx <= '0;
        else if (i_advance)
            r_idx <= r_idx + IDX_W'(1);
    end

    assign o_elem     = r_row_p0[PARTIAL_SUM_BW-1:0];
    assign o_row_last = (r_idx == IDX_W'(MATRIX_SIZE - 1));
endmodule

// File: rtl/result_drain.sv
// Drains a contiguous range of result-SRAM rows to a valid/ready element stream.
// Optional macro RESULT_DRAIN_RELU_EN clamps negative output elements to zero.
module result_drain
    import result_drain_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDRESSSIZE-1:0]           base_addr,
    input  logic [ADDRESSSIZE:0]             num_rows,
    output logic                             rd_en,
    output logic [ADDRESSSIZE-1:0]           rd_addr,
    input  logic [ROW_BW-1:0]                rd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [PARTIAL_SUM_BW-1:0] out_data,
    output logic                             out_row_last,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);
    drain_state_t                     r_state;
    drain_state_t                     w_state_nxt;
    logic [ADDRESSSIZE-1:0]           r_addr;
    logic [ADDRESSSIZE:0]             r_rows_left;
    logic                             w_start_ok;
    logic                             w_fire;
    logic                             w_load;
    logic                             w_row_last;
    logic                             w_final_row;
    logic signed [PARTIAL_SUM_BW-1:0] w_elem;

    function automatic logic signed [PARTIAL_SUM_BW-1:0] relu(
        input logic signed [PARTIAL_SUM_BW-1:0] x
    );
`ifdef RESULT_DRAIN_RELU_EN
        return x[PARTIAL_SUM_BW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_fire      = (r_state == SEND) && out_ready;
    assign w_load      = (r_state == CAPT);
    assign w_final_row = (r_rows_left == (ADDRESSSIZE + 1)'(1));

    row_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start_ok),
        .i_load     (w_load),
        .i_row      (rd_data),
        .i_advance  (w_fire),
        .o_elem     (w_elem),
        .o_row_last (w_row_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Row address wraps naturally at the address width
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_addr      <= base_addr;
            r_rows_left <= num_rows;
        end else if (w_fire && w_row_last && !w_final_row) begin
            r_addr      <= r_addr + ADDRESSSIZE'(1);
            r_rows_left <= r_rows_left - (ADDRESSSIZE + 1)'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        rd_en        = 1'b0;
        rd_addr      = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_row_last = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = (num_rows == '0) ? FIN : READ;
            end
            READ: begin
                rd_en       = 1'b1;
                rd_addr     = r_addr;
                w_state_nxt = CAPT;
            end
            CAPT: w_state_nxt = SEND;
            SEND: begin
                out_valid    = 1'b1;
                out_data     = relu(w_elem);
                out_row_last = w_row_last;
                out_last     = w_row_last && w_final_row;
                if (out_ready && w_row_last)
                    w_state_nxt = w_final_row ? FIN : READ;
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with a registered-read SRAM model and beat scoreboard.
`timescale 1ns/1ps
module tb_result_drain;
    import result_drain_pkg::*;

    localparam int BEAT_W = PARTIAL_SUM_BW + 2;

    logic                             clk;
    logic                             rst;
    logic                             start;
    logic [ADDRESSSIZE-1:0]           base_addr;
    logic [ADDRESSSIZE:0]             num_rows;
    logic                             rd_en;
    logic [ADDRESSSIZE-1:0]           rd_addr;
    logic [ROW_BW-1:0]                rd_data;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [PARTIAL_SUM_BW-1:0] out_data;
    logic                             out_row_last;
    logic                             out_last;
    logic                             busy;
    logic                             done;

    logic [ROW_BW-1:0]      mem [0:(1<<ADDRESSSIZE)-1];
    logic [BEAT_W-1:0]      q_beat[$];
    logic [BEAT_W-1:0]      q_exp[$];
    logic [ADDRESSSIZE-1:0] q_addr[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1, first_cyc = -1, last_cyc = -1, rd_cyc = -1;
    bit prev_stall = 0;
    bit rand_rdy = 0;
    logic [BEAT_W-1:0] prev_beat = '0;

    result_drain dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row_last (out_row_last),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy)
            out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: records reads, accepted beats, done pulses; checks stall stability
    initial forever begin
        @(negedge clk);
        if (rd_en) begin
            q_addr.push_back(rd_addr);
            if (rd_cyc < 0) rd_cyc = cyc;
        end
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_beat", 64'({out_row_last, out_last, out_data}), 64'(prev_beat));
        end
        if (out_valid && out_ready) begin
            q_beat.push_back({out_row_last, out_last, out_data});
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy", 64'(busy), 64'(1));
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_beat  = {out_row_last, out_last, out_data};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [PARTIAL_SUM_BW-1:0] ref_relu(input logic [PARTIAL_SUM_BW-1:0] x);
`ifdef RESULT_DRAIN_RELU_EN
        if (x[PARTIAL_SUM_BW-1]) return '0;
`endif
        return x;
    endfunction

    task automatic fill_row(input int addr, input int mode);
        logic [ROW_BW-1:0] row;
        row = '0;
        for (int k = 0; k < MATRIX_SIZE; k++)
            row[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
                (mode == 0) ? PARTIAL_SUM_BW'(k) : PARTIAL_SUM_BW'($urandom);
        mem[addr] = row;
    endtask

    task automatic expect_row(input int addr, input bit final_row);
        logic [ROW_BW-1:0] row;
        row = mem[addr];
        for (int k = 0; k < MATRIX_SIZE; k++)
            q_exp.push_back({k == MATRIX_SIZE-1, final_row && (k == MATRIX_SIZE-1),
                             ref_relu(row[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW])});
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_beat.delete();
        q_exp.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        first_cyc = -1;
        last_cyc  = -1;
        rd_cyc    = -1;
    endtask

    task automatic kick(input int base, input int rows, output int t0);
        @(negedge clk);
        base_addr = ADDRESSSIZE'(base);
        num_rows  = (ADDRESSSIZE+1)'(rows);
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("done_once", 64'(done_cnt), 64'(1));
    endtask

    task automatic compare_beats(input string tag);
        chk({tag, "_nbeats"}, 64'(q_beat.size()), 64'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_beat.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(q_beat[i]), 64'(q_exp[i]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_en"},    64'(rd_en),        64'(0));
        chk({tag, "_rd_addr"},  64'(rd_addr),      64'(0));
        chk({tag, "_valid"},    64'(out_valid),    64'(0));
        chk({tag, "_data"},     64'(out_data),     64'(0));
        chk({tag, "_row_last"}, 64'(out_row_last), 64'(0));
        chk({tag, "_last"},     64'(out_last),     64'(0));
        chk({tag, "_busy"},     64'(busy),         64'(0));
        chk({tag, "_done"},     64'(done),         64'(0));
    endtask

    initial begin
        int t0;
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single row, element k = k
        fill_row(5, 0);
        clear_mon();
        kick(5, 1, t0);
        wait_done(200);
        chk("t1_nrd", 64'(q_addr.size()), 64'(1));
        if (q_addr.size() > 0) chk("t1_addr", 64'(q_addr[0]), 64'(5));
        chk("t1_rd_lat", 64'(rd_cyc - t0), 64'(1));
        chk("t1_first_lat", 64'(first_cyc - t0), 64'(3));
        chk("t1_span", 64'(last_cyc - first_cyc), 64'(31));
        chk("t1_done_lat", 64'(done_cyc - t0), 64'(35));
        if (q_beat.size() == 32) begin
            chk("t1_beat0", 64'(q_beat[0]), 64'({2'b00, 24'd0}));
            chk("t1_beat31", 64'(q_beat[31]), 64'({2'b11, 24'd31}));
        end
        expect_row(5, 1);
        compare_beats("t1");

        // Three rows across the address wrap, ready held high
        fill_row(1022, 1);
        fill_row(1023, 1);
        fill_row(0, 1);
        clear_mon();
        kick(1022, 3, t0);
        wait_done(400);
        chk("t2_nrd", 64'(q_addr.size()), 64'(3));
        if (q_addr.size() == 3) begin
            chk("t2_addr0", 64'(q_addr[0]), 64'(1022));
            chk("t2_addr1", 64'(q_addr[1]), 64'(1023));
            chk("t2_addr2", 64'(q_addr[2]), 64'(0));
        end
        chk("t2_span", 64'(last_cyc - first_cyc), 64'(99));
        chk("t2_done_lat", 64'(done_cyc - t0), 64'(103));
        expect_row(1022, 0);
        expect_row(1023, 0);
        expect_row(0, 1);
        compare_beats("t2");

        // Same drain with random backpressure
        clear_mon();
        rand_rdy = 1'b1;
        kick(1022, 3, t0);
        wait_done(2000);
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        chk("t3_nrd", 64'(q_addr.size()), 64'(3));
        expect_row(1022, 0);
        expect_row(1023, 0);
        expect_row(0, 1);
        compare_beats("t3");

        // Zero rows: immediate done, no read
        clear_mon();
        kick(7, 0, t0);
        chk("t4_fin_done", 64'(done), 64'(1));
        chk("t4_fin_busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("t4_after_busy", 64'(busy), 64'(0));
        chk("t4_after_done", 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        chk("t4_nrd", 64'(q_addr.size()), 64'(0));
        chk("t4_done_cnt", 64'(done_cnt), 64'(1));
        chk("t4_done_lat", 64'(done_cyc - t0), 64'(1));

        // Two-row drain with ignored start pulses
        fill_row(100, 1);
        fill_row(101, 1);
        clear_mon();
        kick(100, 2, t0);
        repeat (3) begin
            repeat (8) @(negedge clk);
            base_addr = ADDRESSSIZE'(500);
            num_rows  = (ADDRESSSIZE+1)'(5);
            start     = 1'b1;
            @(negedge clk);
            start     = 1'b0;
        end
        wait_done(300);
        chk("t4b_nrd", 64'(q_addr.size()), 64'(2));
        if (q_addr.size() == 2) begin
            chk("t4b_addr0", 64'(q_addr[0]), 64'(100));
            chk("t4b_addr1", 64'(q_addr[1]), 64'(101));
        end
        chk("t4b_done_lat", 64'(done_cyc - t0), 64'(69));
        expect_row(100, 0);
        expect_row(101, 1);
        compare_beats("t4b");

        // Reset in the middle of row 0
        clear_mon();
        kick(5, 1, t0);
        n = 0;
        while (q_beat.size() < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached", 64'(q_beat.size() >= 10), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk_idle("t5_rst");
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt), 64'(0));
        clear_mon();
        kick(5, 1, t0);
        wait_done(200);
        expect_row(5, 1);
        compare_beats("t5");

        // Negative elements
        fill_row(200, 0);
        mem[200][0*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'hFFFFFB;
        mem[200][1*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'h000007;
        mem[200][2*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'h800000;
        clear_mon();
        kick(200, 1, t0);
        wait_done(200);
        if (q_beat.size() >= 3) begin
`ifdef RESULT_DRAIN_RELU_EN
            chk("t6_neg5", 64'(q_beat[0][PARTIAL_SUM_BW-1:0]), 64'h0);
            chk("t6_minneg", 64'(q_beat[2][PARTIAL_SUM_BW-1:0]), 64'h0);
`else
            chk("t6_neg5", 64'(q_beat[0][PARTIAL_SUM_BW-1:0]), 64'hFFFFFB);
            chk("t6_minneg", 64'(q_beat[2][PARTIAL_SUM_BW-1:0]), 64'h800000);
`endif
            chk("t6_pos7", 64'(q_beat[1][PARTIAL_SUM_BW-1:0]), 64'h7);
        end
        expect_row(200, 1);
        compare_beats("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/result_drain.md
# result_drain

Streams stored matrix–vector results out of the result SRAM. One `start` pulse causes it to:
- read a contiguous range of result rows through the SRAM's read port;
- unpack each `PARTIAL_SUM_BW*MATRIX_SIZE`-bit row into per-element beats;
- send the beats to the host over a valid/ready stream.

It is the reader at the far end of the path where the vector multiplier writes results into SRAM, and it runs after the compute controller signals end.

## Interface
- `ADDRESSSIZE`, 10, result SRAM address width
- `PARTIAL_SUM_BW`, 24, signed element width
- `MATRIX_SIZE`, 32, elements per row
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  one-cycle command pulse; sampled only in IDLE
- `base_addr`  in  ADDRESSSIZE  first row address, captured on `start`
- `num_rows`  in  ADDRESSSIZE+1  rows to drain, captured on `start`
- `rd_en`  out  1  SRAM read strobe
- `rd_addr`  out  ADDRESSSIZE  SRAM read address
- `rd_data`  in  PARTIAL_SUM_BW*MATRIX_SIZE  SRAM data, valid the cycle after `rd_en`
- `out_valid`  out  1  element beat valid
- `out_ready`  in  1  host accepts beat
- `out_data`  out  PARTIAL_SUM_BW  signed element
- `out_row_last`  out  1  last element of a row
- `out_last`  out  1  last element of the last row
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, READ, CAPT, SEND, FIN.
- IDLE
  - On `start`: latch `base_addr` and `num_rows`, clear the element index.
  - Go to FIN if `num_rows`==0, else to READ.
- READ: drive `rd_en`=1 and `rd_addr`=current row address for exactly one cycle, then go to CAPT.
- CAPT: load `rd_data` into the row shift register, then go to SEND.
- SEND
  - `out_valid`=1 and `out_data`=element[idx], where element k = bits [k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]; element 0 is sent first.
  - On `out_valid && out_ready`, idx increments.
  - After element MATRIX_SIZE-1 is accepted: if rows remain, the row address increments and the FSM goes to READ; otherwise it goes to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- Row address wraps modulo 2^ADDRESSSIZE; e.g. base 1023, 2 rows reads 1023 then 0.
- `num_rows` up to 2^ADDRESSSIZE is legal; that value drains the whole SRAM once.
- `start` outside IDLE is ignored; parameters captured earlier are unaffected.
- Stream rules:
  - While `out_valid && !out_ready`: `out_data`, `out_row_last` and `out_last` hold stable.
  - `out_valid` never drops without a handshake.
- `out_row_last` = (idx==MATRIX_SIZE-1) while in SEND. `out_last` = `out_row_last` AND final row.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_row_last`=0, `out_last`=0, `busy`=0, `done`=0. State is IDLE.
- `start` at edge t: `rd_en` high in cycle t+1, data captured at edge t+2, first `out_valid` in cycle t+3.
- With `out_ready` held high:
  - each row takes MATRIX_SIZE+2 cycles (2-cycle READ/CAPT bubble between rows);
  - `done` is high MATRIX_SIZE·N + 2N + 1 cycles after `start`.
- `num_rows`=0: `done` in cycle t+1 with no `rd_en`, and `busy` high that cycle only.
- `rst` mid-operation: next cycle is IDLE with all outputs at reset values. The partial stream is abandoned and no `done` is issued.
- `busy` and `done` are never low/high together: `done` asserts in FIN while `busy` is still high.

## Configuration
- `RESULT_DRAIN_RELU_EN`
  - Defined: negative elements are output as 0 (ReLU applied on `out_data`, combinational from the shift register).
  - Undefined: elements pass unmodified as signed two's complement.
- The macro has no effect on timing or handshake.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE/READ/CAPT/SEND/FIN);
  - a `ROW_BW` = PARTIAL_SUM_BW*MATRIX_SIZE constant, also used by the result SRAM and vector multiplier.
- One sub-module, `row_serializer`:
  - loadable row register with element-index counter and `row_last` flag;
  - parent FSM drives load/advance.

## Test plan
- Reset then `start`, base=5, rows=1, row filled with element k = k, `out_ready`=1 → `rd_addr`=5 once; `out_data` 0..31 on consecutive cycles; `out_row_last`/`out_last` on 31; `done` at t+35.
- rows=3, base=1022, random data, `out_ready`=1 → reads 1022, 1023, 0 in order; 96 beats; two 2-cycle bubbles; single `done`.
- Same as above with `out_ready` toggling pseudo-randomly → data and last flags held stable during every stall; beat sequence identical to the no-stall run.
- rows=0 → no `rd_en`; `done` one cycle after `start`; `start` pulses during a 2-row drain are ignored.
- Assert `rst` at beat 10 of row 0 → next cycle all outputs 0; no `done`; a fresh `start` drains correctly from element 0.
- Element -5 (0xFFFFFB) → output 0 with `RESULT_DRAIN_RELU_EN`, 0xFFFFFB without it.
